// File: rtl/output_port_arbiter_if.sv
// Arbiter bus: requests, heads/tails, dst VCs, on/off, grants.
// master drives requests; slave (arbiter) returns grant/lock/stall.
interface output_port_arbiter_if #(
  parameter int NUM_REQ = 20,
  parameter int VC_NUM  = 2
);
  localparam int VC_W = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
  localparam int OW   = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]      req_i;
  logic [NUM_REQ-1:0]      head_i;
  logic [NUM_REQ-1:0]      tail_i;
  logic [NUM_REQ*VC_W-1:0] dst_vc_i;
  logic [VC_NUM-1:0]       on_off_i;
  logic                    stall_clr_i;
  logic [NUM_REQ-1:0]      grant_o;
  logic [VC_W-1:0]         grant_vc_o;
  logic                    valid_o;
  logic                    locked_o;
  logic [OW-1:0]           owner_o;
  logic                    stall_err_o;

  modport master (
    output req_i, head_i, tail_i,
    output dst_vc_i, on_off_i,
    output stall_clr_i,
    input  grant_o, grant_vc_o,
    input  valid_o, locked_o,
    input  owner_o, stall_err_o
  );

  modport slave (
    input  req_i, head_i, tail_i,
    input  dst_vc_i, on_off_i,
    input  stall_clr_i,
    output grant_o, grant_vc_o,
    output valid_o, locked_o,
    output owner_o, stall_err_o
  );
endinterface

// File: rtl/output_port_arbiter.sv
// Per-output-port wormhole RR arbiter with stall watchdog.
// Ports: clk, rst (async, active low), bus (slave modport).
module output_port_arbiter #(
  parameter int NUM_REQ     = 20,
  parameter int VC_NUM      = 2,
  parameter int STALL_LIMIT = 64
) (
  input  logic clk,
  input  logic rst,
  output_port_arbiter_if.slave bus
);
  localparam int VC_W =
    (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
  localparam int OW = $clog2(NUM_REQ);
  localparam int CW = $clog2(STALL_LIMIT + 1);
  localparam logic [CW-1:0] LIM =
    CW'(STALL_LIMIT);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t          state;
  logic [OW-1:0]   rr_ptr;
  logic [OW-1:0]   owner;
  logic [CW-1:0]   stall_cnt;
  logic            stall_err;

  logic [VC_W-1:0]    dst [NUM_REQ];
  logic [NUM_REQ-1:0] vc_on;
  logic [NUM_REQ-1:0] eligible;
  logic               found;
  logic [OW-1:0]      win;
  logic [OW:0]        idx;
  logic               own_go;
  logic [NUM_REQ-1:0] grant;
  logic [VC_W-1:0]    grant_vc;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
    assign dst[g] =
      bus.dst_vc_i[g*VC_W +: VC_W];
    assign vc_on[g] = bus.on_off_i[dst[g]];
    assign eligible[g] =
      bus.req_i[g] & bus.head_i[g] & vc_on[g];
  end

  // First eligible after rr_ptr, wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = {1'b0, rr_ptr} + (OW+1)'(k);
      if (idx >= (OW+1)'(NUM_REQ))
        idx = idx - (OW+1)'(NUM_REQ);
      if (!found && eligible[idx[OW-1:0]]) begin
        found = 1'b1;
        win   = idx[OW-1:0];
      end
    end
  end

  assign own_go =
    bus.req_i[owner] & vc_on[owner];

  always_comb begin
    grant    = '0;
    grant_vc = '0;
    if (rst) begin
      unique case (1'b1)
        (state == IDLE): begin
          if (found) begin
            grant[win] = 1'b1;
            grant_vc   = dst[win];
          end
        end
        (state == LOCKED): begin
          if (own_go) begin
            grant[owner] = 1'b1;
            grant_vc     = dst[owner];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      rr_ptr    <= OW'(NUM_REQ - 1);
      owner     <= '0;
      stall_cnt <= '0;
      stall_err <= 1'b0;
    end else begin
      unique case (1'b1)
        (state == IDLE): begin
          if (found) begin
            owner <= win;
            if (bus.tail_i[win]) begin
              rr_ptr <= win;
            end else begin
              state     <= LOCKED;
              stall_cnt <= '0;
            end
          end
        end
        (state == LOCKED): begin
          if (own_go) begin
            if (bus.tail_i[owner]) begin
              state  <= IDLE;
              rr_ptr <= owner;
            end else begin
              stall_cnt <= '0;
            end
          end else if (stall_cnt != LIM) begin
            stall_cnt <= stall_cnt + 1'b1;
            if (stall_cnt == LIM - 1'b1)
              stall_err <= 1'b1;
          end
        end
        default: ;
      endcase
      // Clear beats a coincident set.
      if (bus.stall_clr_i) begin
        stall_err <= 1'b0;
        stall_cnt <= '0;
      end
    end
  end

  assign bus.grant_o     = grant;
  assign bus.grant_vc_o  = grant_vc;
  assign bus.valid_o     = |grant;
  assign bus.locked_o    = (state == LOCKED);
  assign bus.owner_o     = owner;
  assign bus.stall_err_o = stall_err;
endmodule
